// File: rtl/wdt_reset_seq.sv
// Watchdog reset sequencer: timed sys_rst, boot-confirmation window, failed-boot lockout.
// Optional CAUSE register at offset 4 enabled by defining WDT_RSTSEQ_CAUSE_EN.
module wdt_reset_seq #(
    parameter logic [4:0] BASE_ADDR      = 5'h4,
    parameter logic [7:0] DEFAULT_HOLD   = 8'h10,
    parameter logic [7:0] DEFAULT_WINDOW = 8'hff,
    parameter logic [3:0] MAX_ATTEMPTS   = 4'd3,
    parameter logic [7:0] BOOT_OK_VALUE  = 8'h5a
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       wdt_strobe,
    input  logic       wdt_recovery,
    input  logic       boot_ok,
    output logic       sys_rst,
    output logic       recovery_mode,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        BOOT    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

`ifdef WDT_RSTSEQ_CAUSE_EN
    localparam logic [4:0] NUM_REGS = 5'd5;
`else
    localparam logic [4:0] NUM_REGS = 5'd4;
`endif

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] attempts, attempts_n, attempts_inc;
    logic       final_q, final_n;
    logic       en, en_n;
    logic [7:0] hold, hold_n;
    logic [7:0] window, window_n;
    logic       recovery_n, irq_n;

    logic [4:0] off;
    logic       in_range;
    logic       wr_ctrl, wr_hold, wr_window, wr_stat;
    logic       soft_trig, boot_confirm;

    // Offset wraps for addresses below BASE_ADDR, so one compare bounds both sides.
    assign off       = csr_a - BASE_ADDR;
    assign in_range  = (off < NUM_REGS);
    assign wr_ctrl   = csr_we && (off == 5'd0);
    assign wr_hold   = csr_we && (off == 5'd1);
    assign wr_window = csr_we && (off == 5'd2);
    assign wr_stat   = csr_we && (off == 5'd3);

    assign soft_trig    = wr_ctrl && csr_di[7];
    assign boot_confirm = boot_ok || (wr_stat && (csr_di == BOOT_OK_VALUE));
    assign attempts_inc = (attempts == 4'hf) ? attempts : attempts + 4'd1;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        attempts_n = attempts;
        final_n    = final_q;
        recovery_n = recovery_mode;
        irq_n      = 1'b0;
        en_n       = wr_ctrl   ? csr_di[0] : en;
        hold_n     = wr_hold   ? csr_di    : hold;
        window_n   = wr_window ? csr_di    : window;

        case (state)
            IDLE: begin
                if (en && (wdt_strobe || soft_trig)) begin
                    state_n = ASSERT;
                    cnt_n   = hold;
                    irq_n   = 1'b1;
                end else if (en && wdt_recovery) begin
                    state_n    = ASSERT;
                    cnt_n      = hold;
                    final_n    = 1'b1;
                    recovery_n = 1'b1;
                    irq_n      = 1'b1;
                end
            end
            ASSERT: begin
                if (ce) begin
                    if (cnt == 8'd0) begin
                        if (final_q) begin
                            state_n = LOCKOUT;
                            irq_n   = 1'b1;
                        end else begin
                            state_n    = BOOT;
                            cnt_n      = window;
                            attempts_n = attempts_inc;
                        end
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            BOOT: begin
                if (boot_confirm) begin
                    state_n    = IDLE;
                    attempts_n = '0;
                end else if (wdt_strobe) begin
                    state_n = ASSERT;
                    cnt_n   = hold;
                    irq_n   = 1'b1;
                end else if (ce && (window != 8'd0)) begin
                    if (cnt == 8'd0) begin
                        state_n = ASSERT;
                        cnt_n   = hold;
                        irq_n   = 1'b1;
                        if (attempts >= MAX_ATTEMPTS) begin
                            final_n    = 1'b1;
                            recovery_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            LOCKOUT: begin
                if (wr_ctrl && !csr_di[1]) begin
                    state_n    = IDLE;
                    recovery_n = 1'b0;
                    attempts_n = '0;
                    final_n    = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            attempts      <= '0;
            final_q       <= 1'b0;
            en            <= 1'b1;
            hold          <= DEFAULT_HOLD;
            window        <= DEFAULT_WINDOW;
            sys_rst       <= 1'b0;
            recovery_mode <= 1'b0;
            irq           <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            attempts      <= attempts_n;
            final_q       <= final_n;
            en            <= en_n;
            hold          <= hold_n;
            window        <= window_n;
            sys_rst       <= (state_n == ASSERT);
            recovery_mode <= recovery_n;
            irq           <= irq_n;
        end
    end

`ifdef WDT_RSTSEQ_CAUSE_EN
    logic [2:0] cause, cause_n;
    logic       wr_cause;

    assign wr_cause = csr_we && (off == 5'd4);

    // Every ASSERT entry comes from IDLE or BOOT, so the code follows from the entry inputs.
    always_comb begin
        cause_n = wr_cause ? '0 : cause;
        if ((state_n == ASSERT) && (state != ASSERT)) begin
            if (final_n)
                cause_n = 3'd4;
            else if (wdt_strobe)
                cause_n = 3'd1;
            else if (state == IDLE)
                cause_n = 3'd2;
            else
                cause_n = 3'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cause <= '0;
        else
            cause <= cause_n;
    end
`endif

    always_comb begin
        csr_do = '0;
        if (in_range) begin
            case (off)
                5'd0: csr_do = {6'b0, recovery_mode, en};
                5'd1: csr_do = hold;
                5'd2: csr_do = window;
                5'd3: csr_do = {attempts, state, 2'b00};
`ifdef WDT_RSTSEQ_CAUSE_EN
                5'd4: csr_do = {5'b0, cause};
`endif
                default: csr_do = '0;
            endcase
        end
    end

endmodule

// File: doc/wdt_reset_seq.md
Name: wdt_reset_seq

Overview:
- Sequences the board reset and recovery response to watchdog bites.
- Consumes the watchdog's bite strobe and recovery level. Drives a timed system reset request, then opens a boot-confirmation window. Counts failed boots and, after MAX_ATTEMPTS consecutive failures, issues one final reset into sticky recovery mode.
- Sits beside the watchdog on the same 5-bit CSR bus. Its own rst must come from the power-on domain and never from sys_rst.

Parameters:
- BASE_ADDR, 5'h4: CSR base address; uses 4 registers.
- DEFAULT_HOLD, 8'h10: reset value of the HOLD register (ce ticks of sys_rst).
- DEFAULT_WINDOW, 8'hff: reset value of the WINDOW register (ce ticks allowed for boot confirmation; 0 = no timeout).
- MAX_ATTEMPTS, 4'd3: consecutive failed boots before lockout; range 1..15.
- BOOT_OK_VALUE, 8'h5a: STAT write value that confirms boot.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted at 0)
- ce  in  1  timebase tick, one-cycle pulse
- csr_a  in  5  CSR address
- csr_di  in  8  CSR write data
- csr_we  in  1  CSR write strobe
- csr_do  out  8  CSR read data, combinational on csr_a; 0 outside own range
- wdt_strobe  in  1  one-cycle bite pulse from the watchdog
- wdt_recovery  in  1  level: watchdog failsafe bite
- boot_ok  in  1  one-cycle boot-confirmation pulse from hardware
- sys_rst  out  1  registered system reset request, active-high
- recovery_mode  out  1  registered, sticky recovery indication
- irq  out  1  registered one-cycle pulse

Behaviour:
- States: IDLE=0, ASSERT=1, BOOT=2, LOCKOUT=3. Internal signals: cnt[7:0], attempts[3:0], final flag, en.
- Reset (rst==0 at clk edge):
  - State and outputs: state=IDLE, sys_rst=0, recovery_mode=0, irq=0, attempts=0, final=0.
  - Registers: en=1, hold=DEFAULT_HOLD, window=DEFAULT_WINDOW.
- sys_rst is 1 exactly when state==ASSERT, registered with no combinational path. recovery_mode is 1 in LOCKOUT and also during the final ASSERT.
- IDLE exits, when en=1:
  - wdt_strobe, or CTRL write with di[7]=1 -> ASSERT, cnt<=hold, irq pulse.
  - wdt_recovery=1 -> ASSERT with final=1, recovery_mode<=1, irq pulse.
- ASSERT:
  - cnt decrements on ce. On a ce with cnt==0: if final=1 -> LOCKOUT; else -> BOOT with cnt<=window and attempts<=attempts+1 (saturating at 15).
  - hold=0 gives sys_rst high until the first ce. wdt_strobe and wdt_recovery are ignored in ASSERT.
- BOOT:
  - boot_ok, or a STAT write of BOOT_OK_VALUE -> IDLE, attempts<=0.
  - Else wdt_strobe -> ASSERT, cnt<=hold, irq pulse.
  - Else, on a ce with cnt==0 and window!=0: if attempts>=MAX_ATTEMPTS -> ASSERT with final=1 and recovery_mode<=1; else -> ASSERT with cnt<=hold. Either path pulses irq.
  - Otherwise cnt decrements on ce while window!=0.
  - Priority: boot_ok > wdt_strobe > window expiry.
- LOCKOUT:
  - No further resets; strobes are ignored.
  - Exit only by a CTRL write with di[1]=0 -> IDLE, recovery_mode<=0, attempts<=0, final<=0. An irq pulse is issued on entry.
- en=0 blocks only IDLE exits; a sequence already in flight completes.
- CSR map (offsets from BASE_ADDR):
  - 0 CTRL: rd {6'b0, recovery_mode, en}; wr [0]=en, [1]=0 clears lockout, [7]=1 triggers a soft reset.
  - 1 HOLD: rw.
  - 2 WINDOW: rw.
  - 3 STAT: rd {attempts, state, 2'b0}; a write of BOOT_OK_VALUE confirms boot, other values are ignored.
- HOLD/WINDOW writes take effect at the next cnt load and never alter a running cnt.

Optional Feature:
- Macro: WDT_RSTSEQ_CAUSE_EN.
- Defined: adds register offset 4 CAUSE, rd {5'b0, cause[2:0]}, latched on every ASSERT entry. Encoding: 1=wdt_strobe, 2=soft trigger, 3=window timeout, 4=wdt_recovery or final attempt. The register is cleared by rst, not by sys_rst, and is written by any CSR write to offset 4 (clears to 0).
- Undefined: offset 4 reads 0, no extra flops.

Test Plan:
- hold=3, ce every cycle, pulse wdt_strobe in IDLE -> sys_rst=1 for 4 ce ticks starting next cycle, irq one pulse, then state=BOOT, attempts=1.
- After the bite, boot_ok pulse at BOOT tick 5 with window=10 -> state IDLE, attempts=0, sys_rst stays 0.
- window=2, MAX_ATTEMPTS=3, never confirm -> three normal resets, then a fourth final reset with recovery_mode=1, then LOCKOUT; STAT reads attempts=3, state=3.
- In LOCKOUT, pulse wdt_strobe -> no sys_rst. Write CTRL=8'h01 -> IDLE, recovery_mode=0.
- boot_ok and window expiry in the same cycle -> IDLE, no reset. wdt_recovery while en=0 -> nothing.
- Drive rst=0 mid-ASSERT -> next cycle sys_rst=0, HOLD reads 8'h10, CTRL reads 8'h01.
